spec_power_accum_48bit: RTL and testbench
=========================================

Name: spec_power_accum_48bit

Overview:
- Upstream neighbour of the 48-bit digital gain stage.
- Takes complex FFT bins (16-bit I/Q) tagged with en_sync/cnt_sync.
- Computes per-bin power re^2+im^2 and integrates it across acc_len consecutive spectra in an FFT_POINT x 48 bit BRAM.
- On the last spectrum of each integration, streams the 48-bit sums out with realigned sync, plus an ms_out frame marker that drives the gain stage's max-search ms_in.

Parameters:
- BITWIDTH, 7: sync index width parameter; cnt_sync ports are BITWIDTH+2 bits.
- FFT_POINT, 512: bins per spectrum. Must satisfy FFT_POINT <= 2^(BITWIDTH+2) and FFT_POINT >= 8.
- ACC_W, 48: accumulator width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- re_in  in  16  signed real part of FFT bin
- im_in  in  16  signed imaginary part of FFT bin
- en_sync_in  in  1  bin valid
- cnt_sync_in  in  BITWIDTH+2  bin index, 0..FFT_POINT-1
- acc_len  in  16  spectra per integration; 0 is treated as 1
- para_out  out  48  integrated power of one bin
- en_sync_out  out  1  para_out valid
- cnt_sync_out  out  BITWIDTH+2  bin index of para_out
- ms_out  out  1  one-cycle pulse coincident with bin 0 of each dump
- ovf_out  out  1  high with any output bin whose sum saturated or wrapped

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs 0; FSM to ALIGN; spectrum counter 0; pipeline valids 0. BRAM contents are not cleared.
- FSM, ALIGN: discard input until en_sync_in=1 with cnt_sync_in=0. That bin starts an integration; go to ACCUM.
- FSM, ACCUM:
  - Spectrum counter spec_cnt increments when a valid bin with index FFT_POINT-1 is processed.
  - On the final spectrum (spec_cnt == len_lat-1), spec_cnt returns to 0.
- acc_len latching: acc_len is latched into len_lat on each bin 0 with spec_cnt=0. Changes mid-integration have no effect.
- Order check: if a valid bin index is not previous+1 (mod FFT_POINT) while in ACCUM, abort to ALIGN. The offending bin is reprocessed as the ALIGN check, so a bin 0 restarts immediately. No output is produced for the aborted integration.
- Pipeline (en_sync_in bubbles allowed; valid travels with data):
  - S1: register inputs; issue BRAM read at cnt_sync_in.
  - S2: re^2, im^2 as 32-bit products.
  - S3: pwr = re^2+im^2 (32 bits unsigned; max 2^31 fits). BRAM read data is available.
  - S4:
    - sum = first ? pwr : rd+pwr (zero-extended to 48 bits), where first = (spec_cnt==0).
    - Write sum back.
    - If last: drive outputs with en_sync_out=1, cnt_sync_out=index, ms_out=(index==0).
- Latency: exactly 4 clk from input bin to output on the dump spectrum; en_sync_out=0 on all other spectra.
- Hazards: read and write addresses are distinct within the 3-cycle window because consecutive valid bins differ and FFT_POINT >= 8. No bypass is required.
- acc_len=1: every spectrum is dumped; BRAM is written but never read back as live data.
- Overflow handling is per Optional Feature. ovf_out follows the same timing as en_sync_out.
- Reset mid-integration: partial sums are abandoned. The first-spectrum overwrite makes stale BRAM content harmless.

Optional Feature:
- Macro: SPEC_ACC_SAT_EN.
- Defined: sum clamps to 2^48-1 on carry out of bit 47, and ovf_out=1 for that bin.
- Undefined: sum wraps modulo 2^48, and ovf_out=1 for that bin on carry out. The saturation logic is absent.

Decomposition:
- Shared package spec_pkg holds:
  - ACC_W=48, IQ_W=16, PWR_W=32
  - FSM state enum {ALIGN, ACCUM}
  - sync-index width function (BITWIDTH+2)
- One sub-module, spec_acc_bram: simple dual-port FFT_POINT x ACC_W RAM with 1-cycle synchronous read, inferred.

Test Plan:
- acc_len=1; re=3, im=4 for every bin -> each bin outputs para_out=25 exactly 4 clk after input; ms_out pulses once per spectrum at bin 0.
- acc_len=4; bin k has re=k, im=0 -> one dump after 4 spectra with para_out=4*k^2 and cnt_sync_out=k; en_sync_out=0 during spectra 1-3.
- acc_len=3 with random bubbles (en_sync_in low about 30%) -> results match a reference model; latency counted in clk, unaffected by bubbles.
- Start stream mid-spectrum at bin 100 -> no accumulation until bin 0; first dump is complete. Inject an index jump from 50 to 52 -> integration discarded; realigns at the next bin 0.
- re=im=-32768, acc_len=65535 -> sum 65535*2^31 < 2^48, so no ovf. Preload the BRAM near 2^48 via a forced state -> with SPEC_ACC_SAT_EN, output is 2^48-1 with ovf_out=1; without it, the wrapped value with ovf_out=1.
- Assert rst for 1 clk mid-integration -> all outputs 0 on the next clk; FSM in ALIGN; the next full integration is correct.

Source files
------------

// File: rtl/spec_pkg.sv
// Shared constants, FSM state type and sync-index width helper for the power accumulator.
package spec_pkg;

   localparam int ACC_W = 48;
   localparam int IQ_W  = 16;
   localparam int PWR_W = 32;

   typedef enum logic {
      ALIGN = 1'b0,
      ACCUM = 1'b1
   } state_t;

   function automatic int sync_w(input int bitwidth);
      return bitwidth + 2;
   endfunction

endpackage

// File: rtl/spec_acc_bram.sv
// Simple dual-port accumulator RAM: one write port, one read port with a 1-cycle registered read.
module spec_acc_bram
   import spec_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int WIDTH = spec_pkg::ACC_W,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/spec_power_accum_48bit.sv
// Per-bin power integrator: re^2+im^2 summed over acc_len spectra in BRAM, dumped on the last spectrum.
// Build option SPEC_ACC_SAT_EN: sums clamp to all-ones on overflow; otherwise they wrap modulo 2^ACC_W.
module spec_power_accum_48bit
   import spec_pkg::*;
#(
   parameter int BITWIDTH  = 7,
   parameter int FFT_POINT = 512,
   parameter int ACC_W     = 48
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [IQ_W-1:0]        re_in,
   input  logic signed [IQ_W-1:0]        im_in,
   input  logic                          en_sync_in,
   input  logic [sync_w(BITWIDTH)-1:0]   cnt_sync_in,
   input  logic [15:0]                   acc_len,
   output logic [ACC_W-1:0]              para_out,
   output logic                          en_sync_out,
   output logic [sync_w(BITWIDTH)-1:0]   cnt_sync_out,
   output logic                          ms_out,
   output logic                          ovf_out
);

   localparam int SW = sync_w(BITWIDTH);
   localparam logic [SW-1:0] LAST_IDX = SW'(FFT_POINT - 1);

   state_t        state_reg, state_next;
   logic [15:0]   spec_cnt_reg, spec_cnt_next;
   logic [15:0]   len_lat_reg, len_lat_next;
   logic [SW-1:0] prev_idx_reg, prev_idx_next;

   logic          accept, first, last, in_order, start;
   logic [SW-1:0] next_idx;
   logic [15:0]   spec_base, len_eff;

   // Alignment / order check happens on the incoming bin; first/last travel down the pipe with it.
   always_comb begin
      state_next    = state_reg;
      spec_cnt_next = spec_cnt_reg;
      len_lat_next  = len_lat_reg;
      prev_idx_next = prev_idx_reg;
      accept        = 1'b0;
      first         = 1'b0;
      last          = 1'b0;
      in_order      = 1'b0;
      start         = 1'b0;
      spec_base     = spec_cnt_reg;
      len_eff       = len_lat_reg;
      next_idx      = (prev_idx_reg == LAST_IDX) ? '0 : prev_idx_reg + 1'b1;
      if (en_sync_in) begin
         in_order = (state_reg == ACCUM) && (cnt_sync_in == next_idx);
         start    = !in_order && (cnt_sync_in == '0);
         if (in_order || start) begin
            accept    = 1'b1;
            spec_base = start ? 16'd0 : spec_cnt_reg;
            if ((cnt_sync_in == '0) && (spec_base == 16'd0)) begin
               len_eff = (acc_len == 16'd0) ? 16'd1 : acc_len;
            end
            first         = (spec_base == 16'd0);
            last          = (spec_base == len_eff - 16'd1);
            state_next    = ACCUM;
            len_lat_next  = len_eff;
            prev_idx_next = cnt_sync_in;
            if (cnt_sync_in == LAST_IDX) begin
               spec_cnt_next = last ? 16'd0 : spec_base + 16'd1;
            end else begin
               spec_cnt_next = spec_base;
            end
         end else begin
            state_next    = ALIGN;
            spec_cnt_next = 16'd0;
         end
      end
   end

   logic                   s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic                   s1_first_reg, s2_first_reg, s3_first_reg;
   logic                   s1_last_reg, s2_last_reg, s3_last_reg;
   logic [SW-1:0]          s1_idx_reg, s2_idx_reg, s3_idx_reg;
   logic signed [IQ_W-1:0] s1_re_reg, s1_im_reg;
   logic signed [PWR_W-1:0] re_sq, im_sq;
   logic [PWR_W-1:0]       s2_re_sq_reg, s2_im_sq_reg, s3_pwr_reg;

   assign re_sq = s1_re_reg * s1_re_reg;
   assign im_sq = s1_im_reg * s1_im_reg;

   logic [ACC_W-1:0] rd_data, acc_base, sum;
   logic [ACC_W:0]   sum_ext;
   logic             carry, dump;

   assign acc_base = s3_first_reg ? '0 : rd_data;
   assign sum_ext  = {1'b0, acc_base} + {{(ACC_W + 1 - PWR_W){1'b0}}, s3_pwr_reg};
   assign carry    = sum_ext[ACC_W];
   assign dump     = s3_valid_reg & s3_last_reg;

`ifdef SPEC_ACC_SAT_EN
   assign sum = carry ? '1 : sum_ext[ACC_W-1:0];
`else
   assign sum = sum_ext[ACC_W-1:0];
`endif

   // Read one stage late so the data lands exactly when the S3 power is ready.
   spec_acc_bram #(
      .DEPTH (FFT_POINT),
      .WIDTH (ACC_W),
      .AW    (SW)
   ) u_bram (
      .clk     (clk),
      .rd_en   (s2_valid_reg),
      .rd_addr (s2_idx_reg),
      .rd_data (rd_data),
      .wr_en   (s3_valid_reg),
      .wr_addr (s3_idx_reg),
      .wr_data (sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ALIGN;
         spec_cnt_reg <= 16'd0;
         len_lat_reg  <= 16'd1;
         prev_idx_reg <= '0;
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s3_valid_reg <= 1'b0;
         para_out     <= '0;
         en_sync_out  <= 1'b0;
         cnt_sync_out <= '0;
         ms_out       <= 1'b0;
         ovf_out      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         spec_cnt_reg <= spec_cnt_next;
         len_lat_reg  <= len_lat_next;
         prev_idx_reg <= prev_idx_next;
         s1_valid_reg <= accept;
         s2_valid_reg <= s1_valid_reg;
         s3_valid_reg <= s2_valid_reg;
         para_out     <= dump ? sum : '0;
         en_sync_out  <= dump;
         cnt_sync_out <= dump ? s3_idx_reg : '0;
         ms_out       <= dump & (s3_idx_reg == '0);
         ovf_out      <= dump & carry;
      end
   end

   always_ff @(posedge clk) begin
      s1_re_reg    <= re_in;
      s1_im_reg    <= im_in;
      s1_idx_reg   <= cnt_sync_in;
      s1_first_reg <= first;
      s1_last_reg  <= last;
      s2_re_sq_reg <= re_sq;
      s2_im_sq_reg <= im_sq;
      s2_idx_reg   <= s1_idx_reg;
      s2_first_reg <= s1_first_reg;
      s2_last_reg  <= s1_last_reg;
      s3_pwr_reg   <= s2_re_sq_reg + s2_im_sq_reg;
      s3_idx_reg   <= s2_idx_reg;
      s3_first_reg <= s2_first_reg;
      s3_last_reg  <= s2_last_reg;
   end

endmodule

// File: tb/tb_spec_power_accum_48bit.sv
// Randomised bench for spec_power_accum_48bit against a per-bin integration model with a 4-clk output delay.
// Honours SPEC_ACC_SAT_EN for the expected overflow result.
module tb_spec_power_accum_48bit;

   localparam int BITWIDTH = 7;
   localparam int N        = 512;
   localparam int SW       = BITWIDTH + 2;
   localparam longint unsigned FULL = 64'h0001_0000_0000_0000;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [15:0] re_in = '0;
   logic signed [15:0] im_in = '0;
   logic               en_sync_in = 1'b0;
   logic [SW-1:0]      cnt_sync_in = '0;
   logic [15:0]        acc_len = 16'd1;
   logic [47:0]        para_out;
   logic               en_sync_out;
   logic [SW-1:0]      cnt_sync_out;
   logic               ms_out;
   logic               ovf_out;

   always #5 clk = ~clk;

   spec_power_accum_48bit #(
      .BITWIDTH  (BITWIDTH),
      .FFT_POINT (N),
      .ACC_W     (48)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .re_in        (re_in),
      .im_in        (im_in),
      .en_sync_in   (en_sync_in),
      .cnt_sync_in  (cnt_sync_in),
      .acc_len      (acc_len),
      .para_out     (para_out),
      .en_sync_out  (en_sync_out),
      .cnt_sync_out (cnt_sync_out),
      .ms_out       (ms_out),
      .ovf_out      (ovf_out)
   );

   int errors = 0;
   int checks = 0;
   int n_valid = 0;
   int n_ms = 0;
   int n_ovf = 0;

   task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit              v;
      longint unsigned para;
      int              idx;
      bit              ms;
      bit              ovf;
   } exp_t;

   exp_t            exp_q[$];
   longint unsigned mdl_sum[N];
   bit              mdl_run = 1'b0;
   int              mdl_prev = 0;
   int              mdl_spec = 0;
   int              mdl_len = 1;

   // Reference: integrate each bin over mdl_len spectra; an output appears 4 clk after its input.
   task automatic model_step();
      exp_t            e;
      int              idx;
      longint signed   r;
      longint signed   i;
      longint unsigned s;
      bit              ov;
      e = '{v: 1'b0, para: 0, idx: 0, ms: 1'b0, ovf: 1'b0};
      if (rst) begin
         mdl_run = 1'b0;
         mdl_spec = 0;
         exp_q.delete();
         repeat (3) exp_q.push_back(e);
      end else if (en_sync_in) begin
         idx = int'(cnt_sync_in);
         if (mdl_run && idx != (mdl_prev + 1) % N) mdl_run = 1'b0;
         if (!mdl_run && idx == 0) begin
            mdl_run = 1'b1;
            mdl_spec = 0;
         end
         if (mdl_run) begin
            r = longint'(re_in);
            i = longint'(im_in);
            if (idx == 0 && mdl_spec == 0) mdl_len = (acc_len == 0) ? 1 : int'(acc_len);
            s = (mdl_spec == 0 ? 64'd0 : mdl_sum[idx]) + longint'(r * r + i * i);
            ov = (s >= FULL);
            if (ov) begin
`ifdef SPEC_ACC_SAT_EN
               s = FULL - 1;
`else
               s = s - FULL;
`endif
            end
            mdl_sum[idx] = s;
            if (mdl_spec == mdl_len - 1) e = '{v: 1'b1, para: s, idx: idx, ms: (idx == 0), ovf: ov};
            if (idx == N - 1) mdl_spec = (mdl_spec == mdl_len - 1) ? 0 : mdl_spec + 1;
            mdl_prev = idx;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      e = exp_q.pop_front();
      check_val("en_sync_out", en_sync_out, e.v);
      check_val("ms_out", ms_out, e.ms);
      check_val("ovf_out", ovf_out, e.ovf);
      if (e.v) begin
         check_val("para_out", para_out, e.para);
         check_val("cnt_sync_out", cnt_sync_out, e.idx);
      end
      if (rst) begin
         check_val("rst_para_out", para_out, 0);
         check_val("rst_cnt_sync_out", cnt_sync_out, 0);
      end
      if (en_sync_out) n_valid++;
      if (ms_out) n_ms++;
      if (ovf_out) n_ovf++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic send(input bit v, input int r, input int i, input int idx);
      en_sync_in  = v;
      re_in       = 16'(r);
      im_in       = 16'(i);
      cnt_sync_in = SW'(idx);
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) send(1'b0, 0, 0, 0);
   endtask

   // mode: 0 re=3/im=4, 1 re=k, 2 random, 3 full-scale negative, 4 zero, 5 only bin 5 re=4
   task automatic spectrum(input int mode, input int bub, input int from, input int to);
      int r;
      int i;
      for (int k = from; k <= to; k++) begin
         while (bub > 0 && $urandom_range(99) < bub)
            send(1'b0, int'($urandom_range(65535)), int'($urandom_range(65535)), int'($urandom_range(N - 1)));
         case (mode)
            0: begin r = 3; i = 4; end
            1: begin r = k; i = 0; end
            2: begin r = int'($urandom_range(65535)) - 32768; i = int'($urandom_range(65535)) - 32768; end
            3: begin r = -32768; i = -32768; end
            5: begin r = (k == 5) ? 4 : 0; i = 0; end
            default: begin r = 0; i = 0; end
         endcase
         send(1'b1, r, i, k);
      end
   endtask

   task automatic end_phase(input string name, input int exp_valid, input int exp_ms, input int exp_ovf);
      idle(6);
      check_val({name, "_valid_count"}, n_valid, exp_valid);
      check_val({name, "_ms_count"}, n_ms, exp_ms);
      check_val({name, "_ovf_count"}, n_ovf, exp_ovf);
      $display("phase %s: outputs=%0d ms=%0d ovf=%0d", name, n_valid, n_ms, n_ovf);
      n_valid = 0;
      n_ms = 0;
      n_ovf = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(2);
      end_phase("reset", 0, 0, 0);

      acc_len = 16'd1;
      spectrum(0, 0, 0, N - 1);
      acc_len = 16'd0;
      spectrum(0, 0, 0, N - 1);
      end_phase("len1_3_4", 2 * N, 2, 0);

      acc_len = 16'd4;
      spectrum(1, 0, 0, N - 1);
      spectrum(1, 0, 0, N - 1);
      acc_len = 16'd7;
      spectrum(1, 0, 0, N - 1);
      spectrum(1, 0, 0, N - 1);
      end_phase("len4_ramp", N, 1, 0);

      acc_len = 16'd3;
      repeat (6) spectrum(2, 30, 0, N - 1);
      end_phase("len3_bubbles", 2 * N, 2, 0);

      acc_len = 16'd2;
      spectrum(2, 0, 100, N - 1);
      spectrum(2, 0, 0, N - 1);
      spectrum(2, 0, 0, N - 1);
      spectrum(2, 0, 0, 50);
      spectrum(2, 0, 52, N - 1);
      spectrum(2, 10, 0, N - 1);
      spectrum(2, 10, 0, N - 1);
      end_phase("align_abort", 2 * N, 2, 0);

      acc_len = 16'd3;
      repeat (3) spectrum(3, 0, 0, N - 1);
      end_phase("full_scale", N, 1, 0);

      acc_len = 16'd2;
      spectrum(4, 0, 0, N - 1);
      idle(8);
      dut.u_bram.mem[5] = 48'hFFFF_FFFF_FFF6;
      mdl_sum[5] = FULL - 10;
      spectrum(5, 0, 0, N - 1);
      end_phase("overflow", N, 1, 1);

      acc_len = 16'd2;
      spectrum(2, 0, 0, 299);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      spectrum(2, 0, 300, N - 1);
      spectrum(2, 0, 0, N - 1);
      spectrum(2, 0, 0, N - 1);
      end_phase("mid_reset", N, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
